// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core LSU and a host port.
// Optional performance counters are enabled with DMEM_ARB_PERF_EN.
module dmem_port_arbiter #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [XLEN-1:0]   core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [XLEN-1:0]   core_rdata,
    output logic              core_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [XLEN-1:0]   host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [XLEN-1:0]   host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       conflict_cnt,
    output logic [31:0]       core_stall_cnt
`endif
);

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    owner_t            last_owner;
    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_o;
    logic              push;

    always_comb begin
        core_gnt  = 1'b0;
        host_gnt  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (core_req && (!host_req || last_owner == OWN_HOST)) begin
                core_gnt = 1'b1;
            end else if (host_req) begin
                host_gnt = 1'b1;
            end
        end
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    assign mem_en     = core_gnt | host_gnt;
    assign push       = mem_en & ~mem_we;
    assign core_stall = core_req & ~core_gnt;

    // Return pipe: one {valid, owner} slot per cycle of memory read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= OWN_HOST;
            pipe_v     <= '0;
            pipe_o     <= '0;
        end else begin
            if (mem_en) begin
                last_owner <= host_gnt ? OWN_HOST : OWN_CORE;
            end
            pipe_v[0] <= push;
            pipe_o[0] <= host_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_o[i] <= pipe_o[i-1];
            end
        end
    end

    assign core_rvalid = ~reset & pipe_v[RD_LAT-1] & ~pipe_o[RD_LAT-1];
    assign host_rvalid = ~reset & pipe_v[RD_LAT-1] &  pipe_o[RD_LAT-1];
    assign core_rdata  = mem_rdata;
    assign host_rdata  = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt   <= '0;
            core_stall_cnt <= '0;
        end else begin
            if (core_req && host_req && conflict_cnt != 32'hFFFF_FFFF) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
            if (core_stall && core_stall_cnt != 32'hFFFF_FFFF) begin
                core_stall_cnt <= core_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
